axis_slip_decoder: RTL

AXIS_SLIP_DECODER -- requirements
Module: axis_slip_decoder

---
 rtl/axis_uart_pkg.sv | 15 +
 rtl/axis_slip_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_pkg.sv
// Shared UART/SLIP definitions: SLIP framing bytes and the decoder state encoding.
package axis_uart_pkg;

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_DATA = 2'd1,
    ST_ESC  = 2'd2
  } slip_state_e;

endpackage

// File: rtl/axis_slip_decoder.sv
// SLIP frame decoder between a UART RX AXI-Stream byte source and a framed
// AXI-Stream payload sink.
//   aclk, areset          : clock, asynchronous active-high reset
//   s_axis_tdata[15:0]    : received byte in [7:0]; upper bits ignored
//   s_axis_tuser          : parity error flag for this byte
//   s_axis_tvalid/tready  : input handshake
//   m_axis_tdata[7:0]     : decoded payload byte
//   m_axis_tlast          : last byte of frame
//   m_axis_tuser          : frame error, valid on the tlast beat only
//   m_axis_tvalid/tready  : output handshake
//   frame_count[15:0]     : good frames emitted (wraps)
//   error_count[15:0]     : errored frames emitted (saturates)
module axis_slip_decoder
  import axis_uart_pkg::*;
#(
  parameter int unsigned MAX_FRAME_LEN = 1024,
  parameter bit          SYNC_ON_RESET = 1'b1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] frame_count,
  output logic [15:0] error_count
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned CNT_W = 16;

  slip_state_e      state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             m_user_q, m_user_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       s_ready_c;
  logic       s_accept_c;
  logic [7:0] in_byte;
  logic       in_perr;
  logic       unused_tdata_hi;

  logic       do_payload;
  logic [7:0] payload_byte;
  logic       payload_err;
  logic       do_end;
  logic       end_err;
  logic       frame_err;

  assign s_ready_c       = !m_valid_q || m_axis_tready;
  assign s_accept_c      = s_axis_tvalid && s_ready_c;
  assign in_byte         = s_axis_tdata[7:0];
  assign in_perr         = s_axis_tuser;
  assign unused_tdata_hi = ^s_axis_tdata[15:8];

  // Decode, pending-byte release and output register load.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    err_d        = err_q;
    len_d        = len_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    m_user_d     = m_user_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    do_payload   = 1'b0;
    payload_byte = 8'h00;
    payload_err  = 1'b0;
    do_end       = 1'b0;
    end_err      = 1'b0;
    frame_err    = 1'b0;

    if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    if (s_accept_c) begin
      case (state_q)
        // Parity errors while hunting are discarded with the byte.
        ST_HUNT: begin
          if (in_byte == SLIP_END) begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (in_byte == SLIP_END) begin
            do_end  = 1'b1;
            end_err = in_perr;
          end else if (in_byte == SLIP_ESC) begin
            state_d = ST_ESC;
            err_d   = err_q | in_perr;
          end else begin
            do_payload   = 1'b1;
            payload_byte = in_byte;
            payload_err  = in_perr;
          end
        end
        ST_ESC: begin
          state_d = ST_DATA;
          if (in_byte == SLIP_ESC_END) begin
            do_payload   = 1'b1;
            payload_byte = SLIP_END;
            payload_err  = in_perr;
          end else if (in_byte == SLIP_ESC_ESC) begin
            do_payload   = 1'b1;
            payload_byte = SLIP_ESC;
            payload_err  = in_perr;
          end else if (in_byte == SLIP_END) begin
            do_end  = 1'b1;
            end_err = 1'b1;
          end else begin
            // Invalid escape: keep the raw byte but mark the frame bad.
            do_payload   = 1'b1;
            payload_byte = in_byte;
            payload_err  = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    // A new payload byte pushes the previously pending byte out as a non-last beat.
    if (do_payload) begin
      if (len_q < LEN_W'(MAX_FRAME_LEN)) begin
        if (pend_valid_q) begin
          m_valid_d = 1'b1;
          m_data_d  = pend_data_q;
          m_last_d  = 1'b0;
          m_user_d  = 1'b0;
        end
        pend_valid_d = 1'b1;
        pend_data_d  = payload_byte;
        len_d        = len_q + LEN_W'(1);
        err_d        = err_q | payload_err;
      end else begin
        err_d = 1'b1;
      end
    end

    // END releases the pending byte as tlast; an empty frame leaves no trace.
    if (do_end) begin
      frame_err = err_q | end_err;
      if (pend_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = pend_data_q;
        m_last_d  = 1'b1;
        m_user_d  = frame_err;
        if (frame_err) begin
          if (err_cnt_q != {CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end else begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
      end
      pend_valid_d = 1'b0;
      err_d        = 1'b0;
      len_d        = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= SYNC_ON_RESET ? ST_HUNT : ST_DATA;
      pend_valid_q <= 1'b0;
      pend_data_q  <= 8'h00;
      err_q        <= 1'b0;
      len_q        <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= 8'h00;
      m_last_q     <= 1'b0;
      m_user_q     <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      err_q        <= err_d;
      len_q        <= len_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      m_user_q     <= m_user_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign s_axis_tready = s_ready_c;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign frame_count   = frame_cnt_q;
  assign error_count   = err_cnt_q;

endmodule
